// File: rtl/uart_axi_bridge.sv
// rtl/uart_axi_bridge.sv - byte-stream command bridge to single AXI4-Lite reads/writes (optional UART_BRIDGE_RX_TIMEOUT_EN)
module uart_axi_bridge #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [WIDTH-1:0]      wdata,
    output logic [WIDTH/8-1:0]    wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [WIDTH-1:0]      rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND} state_t;

    state_t             state;
    logic               is_write;
    logic [1:0]         byte_cnt;
    logic [31:0]        addr_r;
    logic [WIDTH-1:0]   wdata_r;
    logic [WIDTH/8-1:0] wstrb_r;
    logic [WIDTH+7:0]   resp_buf;   // {D3,D2,D1,D0,STATUS}, low byte is on tx_data
    logic [2:0]         tx_len;
    logic               aw_done;
    logic               w_done;
    logic               rx_acc;
    logic               tmo_hit;

    assign rx_acc  = rx_valid && rx_ready;
    assign awaddr  = addr_r[ADDR_WIDTH-1:0];
    assign araddr  = addr_r[ADDR_WIDTH-1:0];
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign tx_data = resp_buf[7:0];

`ifdef UART_BRIDGE_RX_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (state == ADDR || state == DATA) && !rx_acc && (tmo_cnt == 32'(TIMEOUT - 1));

    // inter-byte idle counter, only live while a command is being collected
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if ((state == ADDR || state == DATA) && !rx_acc && !tmo_hit)
            tmo_cnt <= tmo_cnt + 32'd1;
        else
            tmo_cnt <= '0;
    end
`else
    // no inter-byte timeout: a partial command waits for its remaining bytes
    assign tmo_hit = 1'b0 && (TIMEOUT > 0);
`endif

    // command parser, AXI sequencer and response shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            is_write <= 1'b0;
            byte_cnt <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wstrb_r  <= '0;
            resp_buf <= '0;
            tx_len   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_acc) begin
                        busy <= 1'b1;
                        if (rx_data == 8'h52 || rx_data == 8'h57) begin
                            is_write <= (rx_data == 8'h57);
                            byte_cnt <= '0;
                            state    <= ADDR;
                        end else begin
                            resp_buf <= {{WIDTH{1'b0}}, 8'hE1};
                            tx_len   <= 3'd1;
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= SEND;
                        end
                    end
                end
                ADDR: begin
                    if (rx_acc) begin
                        addr_r   <= {rx_data, addr_r[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                rx_ready <= 1'b0;
                                arvalid  <= 1'b1;
                                state    <= RD_REQ;
                            end
                        end
                    end else if (tmo_hit) begin
                        resp_buf <= {{WIDTH{1'b0}}, 8'hE2};
                        tx_len   <= 3'd1;
                        tx_valid <= 1'b1;
                        rx_ready <= 1'b0;
                        state    <= SEND;
                    end
                end
                DATA: begin
                    if (rx_acc) begin
                        wdata_r  <= {rx_data, wdata_r[WIDTH-1:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            rx_ready <= 1'b0;
                            awvalid  <= 1'b1;
                            wvalid   <= 1'b1;
                            wstrb_r  <= '1;
                            state    <= WR_REQ;
                        end
                    end else if (tmo_hit) begin
                        resp_buf <= {{WIDTH{1'b0}}, 8'hE2};
                        tx_len   <= 3'd1;
                        tx_valid <= 1'b1;
                        rx_ready <= 1'b0;
                        state    <= SEND;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; each valid drops after its own handshake
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        resp_buf <= {{WIDTH{1'b0}}, 6'b0, bresp};
                        bready   <= 1'b0;
                        tx_len   <= 3'd1;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid) begin
                        resp_buf <= {rdata, 6'b0, rresp};
                        rready   <= 1'b0;
                        tx_len   <= 3'd5;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (tx_len == 3'd1) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            resp_buf <= {8'h00, resp_buf[WIDTH+7:8]};
                            tx_len   <= tx_len - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axi_bridge.sv
// tb/tb_uart_axi_bridge.sv - vector table, corner sequences and randomized model checks for uart_axi_bridge
module tb_uart_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    uart_axi_bridge #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    localparam int BUDGET = 3000;

    int n_checks = 0;
    int n_pass   = 0;

    // subordinate configuration and observations
    int          aw_hold = 1, w_hold = 1, ar_hold = 1;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // subordinate: readies after a configurable number of valid cycles, immediate B/R
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            awready = awvalid && (aw_wait + 1 >= aw_hold);
            wready  = wvalid  && (w_wait + 1 >= w_hold);
            arready = arvalid && (ar_wait + 1 >= ar_hold);
            if (awvalid && !awready) aw_wait++; else aw_wait = 0;
            if (wvalid && !wready)   w_wait++;  else w_wait = 0;
            if (arvalid && !arready) ar_wait++; else ar_wait = 0;
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            if (arvalid) ar_hi++;
            if (awvalid && awready) begin aw_hs++; cap_awaddr = awaddr; end
            if (wvalid && wready) begin w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
            if (arvalid && arready) begin ar_hs++; cap_araddr = araddr; end
            bvalid = bready; bresp = cfg_resp;
            rvalid = rready; rresp = cfg_resp; rdata = cfg_rdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < BUDGET) begin @(negedge clk); t++; end
        if (!rx_ready) check("rx_accept_timeout", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv(input int n, input int stall, output logic [39:0] got);
        int t = 0;
        logic [7:0] first;
        logic stable = 1'b1;
        got = '0;
        while (!tx_valid && t < BUDGET) begin @(negedge clk); t++; end
        if (!tx_valid) begin check("tx_timeout", 0, 1); return; end
        first = tx_data;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (tx_data !== first || !tx_valid) stable = 1'b0;
        end
        if (stall > 0) check("tx_stable", stable, 1);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!tx_valid && t < BUDGET) begin @(negedge clk); t++; end
            if (!tx_valid) begin check("tx_byte_timeout", 0, 1); break; end
            got[8*i +: 8] = tx_data;
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int awh, input int wh, input int arh, input int stall,
                          input int exp_len, input logic [39:0] exp_resp,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        logic [39:0] got;
        aw_hold = awh; w_hold = wh; ar_hold = arh;
        cfg_resp = resp; cfg_rdata = data;
        aw_hs = 0; w_hs = 0; ar_hs = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
        send_byte(op);
        if (op == 8'h52 || op == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        if (op == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
        recv(exp_len, stall, got);
        check({tag, "_resp"}, got, exp_resp);
        if (op == 8'h57) begin
            check({tag, "_awaddr"}, cap_awaddr, exp_addr);
            check({tag, "_wdata"}, cap_wdata, exp_wdata);
            check({tag, "_wstrb"}, cap_wstrb, 4'hF);
            check({tag, "_hs"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, 24'h010100);
            check({tag, "_valid_cycles"}, {aw_hi[15:0], w_hi[15:0]}, {awh[15:0], wh[15:0]});
        end else if (op == 8'h52) begin
            check({tag, "_araddr"}, cap_araddr, exp_addr);
            check({tag, "_hs"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]}, 24'h000001);
            check({tag, "_arvalid_cycles"}, ar_hi, arh);
        end else begin
            check({tag, "_no_axi"}, aw_hs + w_hs + ar_hs, 0);
        end
        check({tag, "_idle"}, {rx_ready, tx_valid, busy}, 3'b100);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {rx_ready, tx_valid, busy, awvalid, wvalid, bready, arvalid, rready, tx_data, wstrb}, 20'h0);
        check({tag, "_addr"}, {awaddr, araddr}, 64'h0);
        check({tag, "_wdata"}, wdata, 32'h0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          awh, wh, arh, stall, len;
        logic [39:0] exp_resp;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[7];

    // behavioural reference: response bytes derived from the protocol rules
    function automatic void model(input logic [7:0] op, input logic [31:0] data, input logic [1:0] resp,
                                  output int len, output logic [39:0] r);
        if (op == 8'h57) begin len = 1; r = {32'h0, 6'b0, resp}; end
        else if (op == 8'h52) begin len = 5; r = {data, 6'b0, resp}; end
        else begin len = 1; r = 40'hE1; end
    endfunction

    initial begin
        logic [39:0] got;
        vecs[0] = '{8'h57, 32'h40000010, 32'hDEADBEEF, 2'd0, 1, 1, 1, 0,  1, 40'h00,           32'h40000010, 32'hDEADBEEF};
        vecs[1] = '{8'h52, 32'h40000004, 32'h12345678, 2'd0, 1, 1, 1, 0,  5, 40'h12345678_00,  32'h40000004, 32'h0};
        vecs[2] = '{8'h52, 32'h40000008, 32'hCAFEF00D, 2'd2, 1, 1, 5, 0,  5, 40'hCAFEF00D_02,  32'h40000008, 32'h0};
        vecs[3] = '{8'h41, 32'h0,        32'h0,        2'd0, 1, 1, 1, 0,  1, 40'hE1,           32'h0,        32'h0};
        vecs[4] = '{8'h57, 32'h40000020, 32'h0BADC0DE, 2'd0, 4, 1, 1, 0,  1, 40'h00,           32'h40000020, 32'h0BADC0DE};
        vecs[5] = '{8'h52, 32'h40000030, 32'hA5A55A5A, 2'd0, 1, 1, 1, 10, 5, 40'hA5A55A5A_00,  32'h40000030, 32'h0};
        vecs[6] = '{8'h57, 32'h00000003, 32'h11223344, 2'd3, 2, 3, 1, 2,  1, 40'h03,           32'h00000003, 32'h11223344};

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_rx_ready", rx_ready, 1);

        for (int v = 0; v < 7; v++)
            do_txn($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].resp,
                   vecs[v].awh, vecs[v].wh, vecs[v].arh, vecs[v].stall, vecs[v].len,
                   vecs[v].exp_resp, vecs[v].exp_addr, vecs[v].exp_wdata);

        // reset in the middle of an address phase
        send_byte(8'h52);
        send_byte(8'h04);
        send_byte(8'h00);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        check("mid_release", {rx_ready, busy}, 2'b10);
        do_txn("after_reset", 8'h52, 32'h40000004, 32'h87654321, 2'd0, 1, 1, 1, 0,
               5, 40'h87654321_00, 32'h40000004, 32'h0);

`ifdef UART_BRIDGE_RX_TIMEOUT_EN
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        recv(1, 0, got);
        check("timeout_resp", got, 40'hE2);
        check("timeout_no_axi", aw_hs + w_hs + ar_hs, 0);
        check("timeout_idle", {rx_ready, tx_valid, busy}, 3'b100);
`endif

        // randomized traffic against the reference model
        for (int n = 0; n < 25; n++) begin
            logic [7:0]  op;
            logic [31:0] a, d;
            logic [1:0]  rs;
            int          sel, len;
            logic [39:0] er;
            sel = $urandom_range(0, 9);
            if (sel < 4) op = 8'h52;
            else if (sel < 8) op = 8'h57;
            else begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'h52 || op == 8'h57) op = 8'($urandom_range(0, 255));
            end
            a  = $urandom;
            d  = $urandom;
            rs = 2'($urandom_range(0, 3));
            model(op, d, rs, len, er);
            do_txn($sformatf("rnd%0d", n), op, a, d, rs,
                   $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 6),
                   $urandom_range(0, 3), len, er, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_axi_bridge.md
Name: uart_axi_bridge

Overview:
- AXI4-Lite manager that turns a byte-stream command protocol into single AXI4-Lite reads and writes.
- Sits between a host-facing UART byte path and the system bus. Command bytes come from the receive FIFO side; response bytes go to the transmit FIFO side.
- Lets an external host peek and poke any bus subordinate, including the UART peripherals, for debug and bring-up.

Parameters:
- WIDTH, 32, bus data width; fixed at 32, so 4 data bytes per transfer.
- ADDR_WIDTH, 32, AXI address width; command carries 4 address bytes, upper bytes truncated if ADDR_WIDTH < 32.
- TIMEOUT, 1_000_000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  incoming command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts byte; transfer occurs when rx_valid && rx_ready.
- tx_data  out  8  outgoing response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- busy  out  1  high from first command byte accepted until last response byte accepted.
- awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  AXI write address channel.
- wdata/wstrb/wvalid/wready  out/out/out/in  WIDTH/WIDTH/8/1/1  AXI write data channel.
- bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel.
- araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  AXI read address channel.
- rdata/rresp/rvalid/rready  in/in/in/out  WIDTH/2/1/1  AXI read data channel.

Behaviour:
- Protocol (multi-byte fields little-endian):
  - Read: 0x52, A0..A3 -> response STATUS, D0..D3.
  - Write: 0x57, A0..A3, D0..D3 -> response STATUS.
  - STATUS = {6'b0, resp}: 0x00 OKAY, 0x02 SLVERR, 0x03 DECERR.
  - Any other command byte -> single response byte 0xE1.
- States: IDLE, ADDR, DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND.
- rx_ready = 1 in IDLE, ADDR and DATA only. Elsewhere 0; host bytes are backpressured.
- IDLE, on byte accept:
  - 0x52 or 0x57: latch opcode, byte counter = 0, go to ADDR, busy = 1.
  - Other value: load response 0xE1, length 1, go to SEND.
- ADDR: shift 4 bytes into the address register. On the 4th byte go to DATA (write) or RD_REQ (read).
- DATA: shift 4 bytes into the wdata register. On the 4th byte go to WR_REQ.
- WR_REQ:
  - awvalid and wvalid asserted in the same cycle; wstrb = 4'hF.
  - Each valid drops the cycle after its own handshake; order between the two is independent.
  - When both handshakes are done: bready = 1, go to WR_RESP.
- WR_RESP: on bvalid, capture bresp, drop bready, go to SEND with length 1.
- RD_REQ: arvalid = 1 until arready; then rready = 1, go to RD_RESP.
- RD_RESP: on rvalid, capture rdata and rresp, drop rready, go to SEND with length 5.
- Address alignment is not checked; awaddr/araddr are forwarded unmodified. The subordinate decides the response, e.g. SLVERR.
- SEND:
  - tx_valid = 1; tx_data held stable until tx_ready.
  - Bytes go out in order STATUS, D0, D1, D2, D3.
  - After the last accepted byte: tx_valid = 0, busy = 0, go to IDLE.
  - Earliest next command accept is the cycle after return to IDLE.
- AXI valids are never dropped before their handshake. Address and data are stable while valid is high.
- No response timeout: the bridge waits indefinitely for bvalid/rvalid.
- Reset, including mid-transaction: on the cycle after rst is sampled high, all outputs are 0 (rx_ready included).
  - The partial command is discarded; state = IDLE.
  - rx_ready returns to 1 the first cycle rst is low.
  - The system resets the subordinate together with the bridge.
- Back-to-back: a command byte presented in the same cycle as the last tx accept is not consumed until IDLE.

Optional Feature:
- Macro: UART_BRIDGE_RX_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR and DATA; it clears on every accepted byte.
  - When the counter reaches TIMEOUT-1, the partial command is discarded and response 0xE2 is sent via SEND.
  - In all other states the counter is held at 0.
- Undefined: no counter logic; a partial command waits forever for its remaining bytes.

Test Plan:
- Write: bytes 57 10 00 00 40 EF BE AD DE, subordinate bresp=OKAY -> awaddr=0x40000010, wdata=0xDEADBEEF, wstrb=F, one AW and one W handshake; response 00.
- Read: bytes 52 04 00 00 40, subordinate returns rdata=0x12345678 with OKAY -> araddr=0x40000004; response 00 78 56 34 12.
- Error/backpressure:
  - Read with rresp=SLVERR and arready delayed 5 cycles -> arvalid held 5 cycles; response 02 followed by 4 data bytes.
  - Bad command byte 0x41 -> single byte E1, then IDLE.
- Skew/stall:
  - Write with wready 3 cycles before awready -> wvalid drops first, awvalid held, one handshake each.
  - tx_ready low 10 cycles -> tx_data stable throughout.
- Reset/timeout:
  - rst pulsed after 2 address bytes -> all outputs 0; a following full read completes normally.
  - With UART_BRIDGE_RX_TIMEOUT_EN and TIMEOUT=100: 3 bytes then idle -> E2 sent with no AXI activity.
